// File: rtl/ball_pkg.sv
// ball_pkg
//   Types and constants shared by the small, medium and large ball movers.
//   ball_state_t   : ball life cycle (HIDDEN -> ACTIVE -> POPPING -> HIDDEN)
//   FIXED_POINT_SHIFT / FP_WIDTH / fp_t : signed sub-pixel position/velocity format
//   COORD_W        : width of screen coordinates
package ball_pkg;

  typedef enum logic [1:0] {
    HIDDEN,
    ACTIVE,
    POPPING
  } ball_state_t;

  localparam int COORD_W           = 11;
  localparam int FIXED_POINT_SHIFT = 6;
  // sign + 11 integer bits + 6 fraction bits
  localparam int FP_WIDTH          = COORD_W + FIXED_POINT_SHIFT + 1;

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  // Converts an unsigned pixel coordinate into the fixed-point format.
  function automatic fp_t pixel_to_fixed(input logic [COORD_W-1:0] pixel);
    return {1'b0, pixel, {FIXED_POINT_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/ball_rect_window.sv
// ball_rect_window
//   Combinational hit test of the current pixel against a ball's bounding box.
//   Ports:
//     enable          in  1   box exists (ball not hidden)
//     pixelX, pixelY  in  11  current pixel
//     topLeftX/Y      in  11  box top-left corner, pixels
//     offsetX/Y       out 11  pixel - topLeft when inside, else 0
//     InsideRectangle out 1   pixel within the box, both edges inclusive
module ball_rect_window
  import ball_pkg::*;
#(
  parameter int WIDTH  = 35,
  parameter int HEIGHT = 35
) (
  input  logic               enable,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle
);

  // One extra bit on the far edge so a box near column 2047 does not wrap.
  logic [COORD_W:0] right_edge;
  logic [COORD_W:0] bottom_edge;
  logic             inside_x;
  logic             inside_y;

  assign right_edge  = {1'b0, topLeftX} + (COORD_W+1)'(WIDTH - 1);
  assign bottom_edge = {1'b0, topLeftY} + (COORD_W+1)'(HEIGHT - 1);

  assign inside_x = (pixelX >= topLeftX) && ({1'b0, pixelX} <= right_edge);
  assign inside_y = (pixelY >= topLeftY) && ({1'b0, pixelY} <= bottom_edge);

  assign InsideRectangle = enable && inside_x && inside_y;
  assign offsetX = InsideRectangle ? (pixelX - topLeftX) : '0;
  assign offsetY = InsideRectangle ? (pixelY - topLeftY) : '0;

endmodule

// File: rtl/medium_ball_mover.sv
// medium_ball_mover
//   Owns one medium ball: spawn, per-frame physics (gravity, floor bounce,
//   wall reflection), hit -> blinking pop sequence -> popped pulse, and the
//   per-pixel box test feeding the bitmap stage.
//   Ports:
//     clk, resetN              pixel clock, async active-low reset
//     startOfFrame             one-cycle pulse per frame
//     pixelX, pixelY           current pixel
//     spawn, spawnX/Y, spawnDirRight   ball creation request
//     hit                      rope/player collision pulse
//     offsetX/Y, InsideRectangle      box test of the current pixel
//     visible                  ball drawn this frame
//     topLeftX/Y               integer ball position
//     popped                   one-cycle pulse when the pop sequence ends
module medium_ball_mover
  import ball_pkg::*;
#(
  parameter int OBJECT_WIDTH_X   = 35,
  parameter int OBJECT_HEIGHT_Y  = 35,
  parameter int FIXED_POINT_MULT = 64,
  parameter int GRAVITY          = 2,
  parameter int BOUNCE_VY        = -380,
  parameter int SPEED_X          = 60,
  parameter int LEFT_WALL_X      = 0,
  parameter int RIGHT_WALL_X     = 639,
  parameter int FLOOR_Y          = 440,
  parameter int POP_FRAMES       = 32
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawnX,
  input  logic [COORD_W-1:0] spawnY,
  input  logic               spawnDirRight,
  input  logic               hit,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle,
  output logic               visible,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               popped
);

  localparam int POP_W = (POP_FRAMES > 8) ? $clog2(POP_FRAMES) : 3;

  ball_state_t      state, state_next;
  fp_t              pos_x, pos_y, vel_x, vel_y;
  fp_t              pos_x_next, pos_y_next, vel_x_next, vel_y_next;
  logic [POP_W-1:0] pop_cnt, pop_cnt_next;

  // Candidate motion for this frame, before floor/wall corrections.
  fp_t vy_step, px_step, py_step;
  fp_t tlx_step, tly_step;
  logic vel_x_neg, vel_x_pos;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= HIDDEN;
      pos_x   <= '0;
      pos_y   <= '0;
      vel_x   <= '0;
      vel_y   <= '0;
      pop_cnt <= '0;
    end else begin
      state   <= state_next;
      pos_x   <= pos_x_next;
      pos_y   <= pos_y_next;
      vel_x   <= vel_x_next;
      vel_y   <= vel_y_next;
      pop_cnt <= pop_cnt_next;
    end
  end

  assign vy_step   = vel_y + fp_t'(GRAVITY);
  assign px_step   = pos_x + vel_x;
  assign py_step   = pos_y + vy_step;
  assign tlx_step  = px_step >>> FIXED_POINT_SHIFT;
  assign tly_step  = py_step >>> FIXED_POINT_SHIFT;
  assign vel_x_neg = vel_x[FP_WIDTH-1];
  assign vel_x_pos = !vel_x[FP_WIDTH-1] && (vel_x != '0);

  always_comb begin
    state_next   = state;
    pos_x_next   = pos_x;
    pos_y_next   = pos_y;
    vel_x_next   = vel_x;
    vel_y_next   = vel_y;
    pop_cnt_next = pop_cnt;
    popped       = 1'b0;

    case (state)
      HIDDEN: begin
        if (spawn) begin
          pos_x_next = pixel_to_fixed(spawnX);
          pos_y_next = pixel_to_fixed(spawnY);
          vel_x_next = spawnDirRight ? fp_t'(SPEED_X) : -fp_t'(SPEED_X);
          vel_y_next = '0;
          state_next = ACTIVE;
        end
      end

      ACTIVE: begin
        // A hit freezes the ball where it is, even on a frame boundary.
        if (hit) begin
          state_next   = POPPING;
          pop_cnt_next = '0;
        end else if (startOfFrame) begin
          vel_y_next = vy_step;
          pos_x_next = px_step;
          pos_y_next = py_step;
          if (tly_step + fp_t'(OBJECT_HEIGHT_Y) >= fp_t'(FLOOR_Y)) begin
            pos_y_next = fp_t'((FLOOR_Y - OBJECT_HEIGHT_Y) * FIXED_POINT_MULT);
            vel_y_next = fp_t'(BOUNCE_VY);
          end
          if (tlx_step <= fp_t'(LEFT_WALL_X) && vel_x_neg) begin
            pos_x_next = fp_t'(LEFT_WALL_X * FIXED_POINT_MULT);
            vel_x_next = fp_t'(SPEED_X);
          end
          if (tlx_step + fp_t'(OBJECT_WIDTH_X - 1) >= fp_t'(RIGHT_WALL_X) && vel_x_pos) begin
            pos_x_next = fp_t'((RIGHT_WALL_X - OBJECT_WIDTH_X + 1) * FIXED_POINT_MULT);
            vel_x_next = -fp_t'(SPEED_X);
          end
        end
      end

      POPPING: begin
        // popped is raised while still in POPPING so a spawn can never coincide with it.
        if (startOfFrame) begin
          if (pop_cnt == POP_W'(POP_FRAMES - 1)) begin
            state_next   = HIDDEN;
            pop_cnt_next = '0;
            popped       = 1'b1;
          end else begin
            pop_cnt_next = pop_cnt + 1'b1;
          end
        end
      end

      default: state_next = HIDDEN;
    endcase
  end

  // Blink with a 4-frame on / 4-frame off pattern while popping.
  assign visible  = (state == ACTIVE) || ((state == POPPING) && !pop_cnt[2]);
  assign topLeftX = pos_x[FIXED_POINT_SHIFT +: COORD_W];
  assign topLeftY = pos_y[FIXED_POINT_SHIFT +: COORD_W];

  ball_rect_window #(
    .WIDTH (OBJECT_WIDTH_X),
    .HEIGHT(OBJECT_HEIGHT_Y)
  ) u_window (
    .enable         (state != HIDDEN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle)
  );

endmodule
